// File: rtl/fp_pkg.sv
// Shared constants for the minifloat datapath: default format, flag bit
// positions, rounding-mode encodings and the NaN code helper.
package fp_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int MAN_W_DEF = 3;
    localparam int BIAS_DEF  = 7;

    localparam int FLG_NAN  = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_UNF  = 1;
    localparam int FLG_ZERO = 0;

    localparam logic RND_RNE   = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    // The single NaN code is the "negative zero" pattern with mantissa zero.
    function automatic logic [31:0] nan_code(input int w);
        return 32'h1 << (w - 1);
    endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalise, round, saturate and pack a raw minifloat product into the
// encoded word plus its exception flags. Purely combinational.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   sign,
    input  logic [EXP_W+1:0]       exp_sum,
    input  logic [2*MAN_W+1:0]     mant_prod,
    input  logic                   rnd_mode,
    input  logic                   is_nan,
    input  logic                   is_zero,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int W  = 1 + EXP_W + MAN_W;

    localparam logic [W-1:0]         NAN_CODE = W'(nan_code(W));
    localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EMIN     = EW'(1);

    function automatic logic round_inc(input logic rnd, input logic lsb,
                                       input logic guard, input logic sticky);
        return (rnd == RND_RNE) && guard && (sticky || lsb);
    endfunction

    function automatic logic [W-1:0] sat_max(input logic s);
        return {s, {(W-1){1'b1}}};
    endfunction

    logic                   shift;
    logic [PW-1:0]          norm;
    logic [MAN_W-1:0]       mant_t;
    logic                   guard;
    logic                   sticky;
    logic                   inc;
    logic [MAN_W:0]         mant_r;
    logic signed [EW-1:0]   e_fin;

    // Leading one ends up at the top bit; everything below the kept
    // mantissa becomes guard + sticky.
    assign shift  = mant_prod[PW-1];
    assign norm   = shift ? mant_prod : (mant_prod << 1);
    assign mant_t = norm[PW-2 -: MAN_W];
    assign guard  = norm[PW-2-MAN_W];
    assign sticky = |norm[PW-3-MAN_W:0];
    assign inc    = round_inc(rnd_mode, mant_t[0], guard, sticky);
    assign mant_r = {1'b0, mant_t} + (MAN_W+1)'(inc);
    assign e_fin  = $signed(exp_sum) + $signed(EW'(shift)) + $signed(EW'(mant_r[MAN_W]));

    always_comb begin
        result = '0;
        flags  = '0;
        if (is_nan) begin
            result          = NAN_CODE;
            flags[FLG_NAN]  = 1'b1;
        end else if (is_zero) begin
            flags[FLG_ZERO] = 1'b1;
        end else if (e_fin < EMIN) begin
            flags[FLG_UNF]  = 1'b1;
            flags[FLG_ZERO] = 1'b1;
        end else if (e_fin > EMAX) begin
            result          = sat_max(sign);
            flags[FLG_OVF]  = 1'b1;
        end else begin
            result = {sign, e_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Two-stage pipelined minifloat multiplier with valid/ready streaming,
// per-result exception flags and sticky status.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int BIAS  = BIAS_DEF,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   out_flags,
    input  logic         flag_clr,
    output logic [3:0]   sticky_flags
);

    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;

    localparam logic [W-1:0]         NAN_CODE = W'(nan_code(W));
    localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);

    logic [EXP_W-1:0]      e_a, e_b;
    logic signed [EW-1:0]  exp_sum_c;
    logic [PW-1:0]         prod_c;

    assign e_a       = a[W-2 -: EXP_W];
    assign e_b       = b[W-2 -: EXP_W];
    assign exp_sum_c = $signed({2'b00, e_a}) + $signed({2'b00, e_b}) - BIAS_S;
    assign prod_c    = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});

    logic                  vld_p1, vld_p2;
    logic                  sign_p1, rnd_p1, nan_p1, zero_p1;
    logic signed [EW-1:0]  exp_p1;
    logic [PW-1:0]         prod_p1;
    logic                  adv2;
    logic [W-1:0]          res_c;
    logic [3:0]            flg_c;

    assign adv2      = !vld_p2 || out_ready;
    assign in_ready  = !vld_p1 || adv2;
    assign out_valid = vld_p2;

    // ---- stage 1: decode, classify, exponent sum, mantissa product ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            sign_p1 <= a[W-1] ^ b[W-1];
            nan_p1  <= (a == NAN_CODE) || (b == NAN_CODE);
            zero_p1 <= (e_a == '0) || (e_b == '0);
            rnd_p1  <= rnd_mode;
            exp_p1  <= exp_sum_c;
            prod_p1 <= prod_c;
        end
    end

    fp_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .sign      (sign_p1),
        .exp_sum   (exp_p1),
        .mant_prod (prod_p1),
        .rnd_mode  (rnd_p1),
        .is_nan    (nan_p1),
        .is_zero   (zero_p1),
        .result    (res_c),
        .flags     (flg_c)
    );

    // ---- stage 2: normalise/round/pack result drives the outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            result    <= '0;
            out_flags <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result    <= res_c;
                out_flags <= flg_c;
            end
        end
    end

    // Clear first, then OR in the handshake's flags so new flags survive a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_flags <= '0;
        else
            sticky_flags <= (flag_clr ? 4'b0000 : sticky_flags)
                          | ({4{out_valid && out_ready}} & out_flags);
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe at the default E4M3 format.
module tb_fp_mul_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       rnd_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [3:0] out_flags;
    logic       flag_clr = 1'b0;
    logic [3:0] sticky_flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .rnd_mode     (rnd_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .out_flags    (out_flags),
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       rm;
        logic [7:0] r;
        logic [3:0] f;
        string      name;
    } vec_t;

    // Drive one operation with out_ready high; return what appears and when.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic rm,
                          output logic [7:0] res, output logic [3:0] flg, output int lat);
        @(negedge clk);
        a = ia; b = ib; rnd_mode = rm; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        flg = out_flags;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b expected 1", in_ready); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL rst_result got %h expected 00", result); end
        checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL rst_flags got %b expected 0000", out_flags); end
        checks++; if (sticky_flags !== 4'h0) begin errors++; $display("FAIL rst_sticky got %b expected 0000", sticky_flags); end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        vec_t v[13] = '{
            '{8'h38, 8'h38, 1'b0, 8'h38, 4'b0000, "one_x_one"},
            '{8'h3C, 8'h3C, 1'b0, 8'h41, 4'b0000, "1p5_sq"},
            '{8'h39, 8'h3C, 1'b0, 8'h3E, 4'b0000, "tie_rne"},
            '{8'h39, 8'h3C, 1'b1, 8'h3D, 4'b0000, "tie_trunc"},
            '{8'hB8, 8'h38, 1'b0, 8'hB8, 4'b0000, "neg_one"},
            '{8'h7F, 8'h38, 1'b0, 8'h7F, 4'b0000, "max_exact"},
            '{8'h88, 8'h38, 1'b0, 8'h88, 4'b0000, "min_norm_neg"},
            '{8'h7F, 8'h40, 1'b0, 8'h7F, 4'b0100, "ovf_pos"},
            '{8'hFF, 8'h40, 1'b0, 8'hFF, 4'b0100, "ovf_neg"},
            '{8'h80, 8'h38, 1'b0, 8'h80, 4'b1000, "nan_in"},
            '{8'h00, 8'h80, 1'b0, 8'h80, 4'b1000, "nan_over_zero"},
            '{8'h08, 8'h08, 1'b0, 8'h00, 4'b0011, "underflow"},
            '{8'h81, 8'h38, 1'b0, 8'h00, 4'b0001, "neg_zero_in"}
        };
        logic [7:0] res;
        logic [3:0] flg;
        int lat;
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].a, v[i].b, v[i].rm, res, flg, lat);
            checks++;
            if (lat != 2) begin errors++; $display("FAIL %s latency got %0d expected 2", v[i].name, lat); end
            checks++;
            if (res !== v[i].r) begin errors++; $display("FAIL %s result got %h expected %h", v[i].name, res, v[i].r); end
            checks++;
            if (flg !== v[i].f) begin errors++; $display("FAIL %s flags got %b expected %b", v[i].name, flg, v[i].f); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va[6] = '{8'h38, 8'h3C, 8'h39, 8'hB8, 8'h7F, 8'h40};
        logic [7:0] vb[6] = '{8'h38, 8'h3C, 8'h3C, 8'h38, 8'h40, 8'h40};
        logic [7:0] vr[6] = '{8'h38, 8'h41, 8'h3E, 8'hB8, 8'h7F, 8'h48};
        int n_in = 0;
        int n_out = 0;
        int cyc = 0;
        logic [7:0] held = 8'h00;
        logic holding = 1'b0;
        while (n_out < 6 && cyc < 60) begin
            @(negedge clk);
            in_valid = (n_in < 6);
            if (n_in < 6) begin a = va[n_in]; b = vb[n_in]; end
            rnd_mode = 1'b0;
            out_ready = (cyc >= 5);
            #1;
            if (cyc == 4) begin
                checks++;
                if (in_ready !== 1'b0 || n_in != 2)
                    begin errors++; $display("FAIL bp_in_ready got in_ready=%b accepted=%0d expected 0 and 2", in_ready, n_in); end
            end
            if (out_valid && !out_ready) begin
                if (holding) begin
                    checks++;
                    if (result !== held) begin errors++; $display("FAIL bp_hold got %h expected %h", result, held); end
                end
                held = result;
                holding = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (result !== vr[n_out]) begin errors++; $display("FAIL bp_order[%0d] got %h expected %h", n_out, result, vr[n_out]); end
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (n_out != 6) begin errors++; $display("FAIL bp_count got %0d expected 6", n_out); end
    endtask

    task automatic test_sticky();
        logic [7:0] res;
        logic [3:0] flg;
        int lat;
        @(negedge clk); flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        run_op(8'h7F, 8'h40, 1'b0, res, flg, lat);
        @(negedge clk);
        checks++; if (sticky_flags !== 4'b0100) begin errors++; $display("FAIL sticky_ovf got %b expected 0100", sticky_flags); end
        flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        checks++; if (sticky_flags !== 4'b0000) begin errors++; $display("FAIL sticky_clr got %b expected 0000", sticky_flags); end
        run_op(8'h00, 8'h38, 1'b0, res, flg, lat);
        @(negedge clk);
        checks++; if (sticky_flags !== 4'b0001) begin errors++; $display("FAIL sticky_zero got %b expected 0001", sticky_flags); end
        out_ready = 1'b0;
        a = 8'h80; b = 8'h38; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (result !== 8'h80 || !out_valid) begin errors++; $display("FAIL sticky_nan_res got %h valid=%b expected 80 valid=1", result, out_valid); end
        out_ready = 1'b1; flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        checks++; if (sticky_flags !== 4'b1000) begin errors++; $display("FAIL sticky_clr_nan got %b expected 1000", sticky_flags); end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] res;
        logic [3:0] flg;
        int lat;
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b0; rnd_mode = 1'b0;
        a = 8'h3C; b = 8'h3C; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h39; b = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b expected 0", out_valid); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL mid_rst_result got %h expected 00", result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL mid_rst_stale got %0d valid cycles expected 0", stale); end
        run_op(8'h3C, 8'h3C, 1'b0, res, flg, lat);
        checks++; if (res !== 8'h41 || lat != 2) begin errors++; $display("FAIL mid_rst_next got %h lat %0d expected 41 lat 2", res, lat); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_sticky();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
